dispatch: RTL and testbench

- Dispatch queue between decode and issue: a synchronous circular FIFO holding decoded instructions.
- Decode pushes one decoded_instr_t per cycle when w_en is high.
- Issue pops one entry per cycle when r_en is high.
- full and empty flags provide back-pressure to decode and a valid indication to issue.

---
 rtl/dispatch.sv | 81 ++++++++
 tb/tb_dispatch.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dispatch.sv
// Dispatch queue between decode and issue: a circular FIFO of decoded
// instructions with a registered read port and count-derived full/empty flags.

package dispatch_pkg;
  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } decoded_instr_t;
endpackage

module dispatch
  import dispatch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,      // active-high asynchronous reset
  input  logic           w_en,
  input  logic           r_en,
  input  decoded_instr_t instr_in,
  output decoded_instr_t instr_out,
  output logic           full,
  output logic           empty
);

  localparam int PTR_W = $clog2(DEPTH);

  decoded_instr_t   r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_do_wr;
  logic w_do_rd;

  // Flags come straight from the occupancy count, so they track the
  // post-edge state and clear the moment reset empties the queue.
  assign full    = (r_count == (PTR_W+1)'(DEPTH));
  assign empty   = (r_count == '0);

  // Both qualifiers use pre-edge flags: a write while full is dropped even
  // if a pop frees a slot on the same edge, and a read while empty never
  // bypasses the incoming write.
  assign w_do_wr = w_en && !full;
  assign w_do_rd = r_en && !empty;

  // Storage array; contents need no reset since only written slots are read.
  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= instr_in;
    end
  end

  // Pointers, occupancy and the registered read port.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      instr_out <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (w_do_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_rd) begin
        r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
        instr_out <= r_mem[r_rd_ptr];
      end
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_dispatch.sv
// Self-checking bench for the dispatch queue: directed scenarios with literal
// expectations plus a randomized run, all compared against a queue model.

module tb_dispatch;
  import dispatch_pkg::*;

  localparam int DEPTH = 8;
  localparam int IW    = $bits(decoded_instr_t);

  logic           clk;
  logic           rst_n;
  logic           w_en;
  logic           r_en;
  decoded_instr_t instr_in;
  decoded_instr_t instr_out;
  logic           full;
  logic           empty;

  int errs   = 0;
  int checks = 0;

  dispatch #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .w_en      (w_en),
    .r_en      (r_en),
    .instr_in  (instr_in),
    .instr_out (instr_out),
    .full      (full),
    .empty     (empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a plain queue. Pop happens before push so that a read
  // while empty can never see the word being written on the same edge.
  logic [IW-1:0] mq[$];
  logic [IW-1:0] m_out;
  bit            m_dw;
  bit            m_dr;

  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      mq.delete();
      m_out = '0;
    end else begin
      m_dw = w_en && (mq.size() < DEPTH);
      m_dr = r_en && (mq.size() > 0);
      if (m_dr) m_out = mq.pop_front();
      if (m_dw) mq.push_back(instr_in);
    end
  end

  function automatic decoded_instr_t mk(input logic [IW-1:0] v);
    return decoded_instr_t'(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output with the model.
  task automatic cmp_model();
    chk("model.instr_out", 64'(instr_out), 64'(m_out));
    chk("model.full",      64'(full),      64'(mq.size() == DEPTH));
    chk("model.empty",     64'(empty),     64'(mq.size() == 0));
  endtask

  // One clock: drive inputs, take the edge, then compare just after it.
  task automatic cyc(input bit w, input bit r, input logic [IW-1:0] d);
    w_en     = w;
    r_en     = r;
    instr_in = mk(d);
    @(posedge clk);
    #1;
    cmp_model();
  endtask

  // Reset asserted between edges, checked before any clock edge arrives.
  task automatic async_reset();
    @(negedge clk);
    #2;
    w_en  = 1'b0;
    r_en  = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("areset.empty", 64'(empty), 64'd1);
    chk("areset.full",  64'(full),  64'd0);
    chk("areset.out",   64'(instr_out), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
  endtask

  logic [IW-1:0] ones;
  logic [IW-1:0] prev;

  initial begin
    ones     = '1;
    rst_n    = 1'b1;
    w_en     = 1'b0;
    r_en     = 1'b0;
    instr_in = '0;

    // Reset state.
    #4;
    chk("reset.empty", 64'(empty), 64'd1);
    chk("reset.full",  64'(full),  64'd0);
    chk("reset.out",   64'(instr_out), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;

    // Fill with all-ones; empty falls after edge 1, full rises after edge 8.
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(1'b1, 1'b0, ones);
      if (i == 1) chk("fill.empty_after_1", 64'(empty), 64'd0);
      if (i < DEPTH) chk("fill.not_full", 64'(full), 64'd0);
    end
    chk("fill.full_after_8", 64'(full), 64'd1);
    cyc(1'b1, 1'b0, 54'h123);
    chk("fill.9th_dropped", 64'(full), 64'd1);
    // Drain to prove the dropped word never entered.
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, '0);
    chk("fill.drain_empty", 64'(empty), 64'd1);
    chk("fill.last_is_ones", 64'(instr_out), 64'(ones));

    // Asynchronous reset mid-operation.
    cyc(1'b1, 1'b0, 54'h77);
    cyc(1'b1, 1'b0, 54'h78);
    async_reset();

    // Fill with 1..8 then drain in order.
    for (int i = 1; i <= DEPTH; i++) cyc(1'b1, 1'b0, IW'(i));
    chk("drain.full", 64'(full), 64'd1);
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(1'b0, 1'b1, '0);
      chk("drain.order", 64'(instr_out), 64'(i));
    end
    chk("drain.empty", 64'(empty), 64'd1);
    cyc(1'b0, 1'b1, '0);
    cyc(1'b0, 1'b1, '0);
    chk("drain.hold_8", 64'(instr_out), 64'd8);

    // Streaming: reads begin three edges after the first write.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, ones);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1, ones);
      chk("stream.out", 64'(instr_out), 64'(ones));
      chk("stream.full", 64'(full), 64'd0);
      chk("stream.empty", 64'(empty), 64'd0);
    end
    // Occupancy held at 3: three reads exactly empty it.
    cyc(1'b0, 1'b1, '0);
    cyc(1'b0, 1'b1, '0);
    chk("stream.count3_a", 64'(empty), 64'd0);
    cyc(1'b0, 1'b1, '0);
    chk("stream.count3_b", 64'(empty), 64'd1);

    // Simultaneous read and write while empty: write only, no bypass.
    cyc(1'b1, 1'b1, 54'h5);
    chk("emptyrw.empty", 64'(empty), 64'd0);
    chk("emptyrw.out_held", 64'(instr_out), 64'(ones));
    cyc(1'b0, 1'b1, '0);
    chk("emptyrw.read5", 64'(instr_out), 64'h5);
    chk("emptyrw.count1", 64'(empty), 64'd1);

    // Write while full with simultaneous read: read only, count becomes 7.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, IW'(32'h100 + i));
    cyc(1'b1, 1'b1, 54'h999);
    chk("fullrw.out", 64'(instr_out), 64'h100);
    chk("fullrw.not_full", 64'(full), 64'd0);
    for (int i = 1; i < DEPTH; i++) cyc(1'b0, 1'b1, '0);
    chk("fullrw.last", 64'(instr_out), 64'h107);
    chk("fullrw.empty", 64'(empty), 64'd1);

    // Wrap: from a fresh reset, push 6 / pop 6, then A..E across the wrap.
    async_reset();
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, IW'(32'h40 + i));
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, '0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, IW'(32'hA + i));
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, '0);
      chk("wrap.order", 64'(instr_out), 64'(32'hA + i));
    end
    chk("wrap.empty", 64'(empty), 64'd1);

    // Randomized traffic with varying read/write bias, model-checked.
    for (int i = 0; i < 3000; i++) begin
      int wp;
      int rp;
      wp = (i / 500) % 2 ? 70 : 40;
      rp = (i / 500) % 2 ? 40 : 70;
      prev = {$urandom(), $urandom()};
      cyc($urandom_range(99) < wp, $urandom_range(99) < rp, prev);
      if (i == 1700) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
